hawk_controller: RTL
====================

# hawk_controller

Sequencing FSM for the HAWK pedestrian beacon. It owns the shared 4-bit seconds counter in `HAWK_datapath`, clearing it on every phase change and incrementing it once per 1 Hz tick. It also decodes the phase and counter into vehicle and pedestrian lamp drives. It sits between the debounced push-button / tick generator and the lamp drivers, with `HAWK_datapath` as its only timing resource.

## Interface
Parameters (each legal range 1..15; out-of-range is a `$error` at elaboration):
- `T_DARK`, default 5: minimum ticks in DARK before a request is served.
- `T_FLASH_Y`, default 4: flashing-yellow ticks.
- `T_SOLID_Y`, default 3: steady-yellow ticks.
- `T_WALK`, default 7: steady-red / WALK ticks.
- `T_CLEAR`, default 10: wig-wag red / flashing DON'T WALK ticks.

Ports:
- `clk` in 1: system clock. One clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `tick` in 1: single-cycle 1 Hz enable pulse.
- `btn` in 1: single-cycle, already synchronized pedestrian request.
- `count` in 4: from `HAWK_datapath`.
- `clr_count` out 1: to `HAWK_datapath`, combinational. Has priority over `inc_count` in the datapath.
- `inc_count` out 1: to `HAWK_datapath`, combinational.
- `veh_yellow` out 1: vehicle yellow lamp.
- `veh_red_l` out 1: vehicle left red lamp.
- `veh_red_r` out 1: vehicle right red lamp.
- `ped_walk` out 1: pedestrian WALK lamp.
- `ped_dontwalk` out 1: pedestrian DON'T WALK lamp.
- `countdown` out 4: pedestrian countdown display (see Configuration).
- `state` out 3: current phase, for debug. Encodings: DARK=0, FLASH_Y=1, SOLID_Y=2, WALK=3, CLEAR=4.

## Operation
Internal state:
- State register `state`, an init flag `init_done` and a request latch `req_pending`.
- All three reset to DARK / 0 / 0.

Init:
- While `init_done`=0, hold `clr_count`=1, force `inc_count`=0 and block all transitions.
- `init_done` sets on the first clock edge after `rst_n` rises. This clears the unreset datapath count.

Request latch:
- `btn` sets `req_pending`.
- `req_pending` clears on the edge entering FLASH_Y.
- A `btn` in the same cycle as the DARK→FLASH_Y transition is consumed, so `req_pending` stays 0.
- A `btn` in any other state, including FLASH_Y..CLEAR, stays latched until the next service.

Phases:
- DARK:
  - `inc_count` = `tick` && `count` < `T_DARK`, so the count saturates at `T_DARK`.
  - Go to FLASH_Y when `req_pending` && `count` == `T_DARK`.
- Timed phase S in {FLASH_Y, SOLID_Y, WALK, CLEAR}, with duration T:
  - `inc_count` = `tick`.
  - Advance when `tick` && `count` == T-1.
  - Order is FLASH_Y→SOLID_Y→WALK→CLEAR→DARK.
- `clr_count` = 1 in exactly the cycle any transition fires, plus the init cycles.

Lamp decode:
- Lamps are a function of the registered `state` and `count` only. They have no combinational path from `btn` or `tick`.
- Flash phase is `~count[0]` (lamp on during even counts).

| Phase | Vehicle lamps | Pedestrian lamps |
|---|---|---|
| DARK | all vehicle lamps 0 | `ped_dontwalk`=1 |
| FLASH_Y | `veh_yellow`=`~count[0]` | `ped_dontwalk`=1 |
| SOLID_Y | `veh_yellow`=1 | `ped_dontwalk`=1 |
| WALK | `veh_red_l`=`veh_red_r`=1 | `ped_walk`=1 |
| CLEAR | `veh_red_l`=`~count[0]`, `veh_red_r`=`count[0]` | `ped_dontwalk`=`~count[0]` |

- Any lamp not listed for a phase is 0.

Reset values:
- `state`=DARK.
- All vehicle lamps 0.
- `ped_walk`=0, `ped_dontwalk`=1.
- `countdown`=0.
- `clr_count`=1, `inc_count`=0.

Reset asserted mid-cycle: returns immediately, asynchronously, to DARK with the outputs above. `req_pending` is lost.

## Timing
- Each timed phase lasts exactly T ticks. The count enters at 0 and exits on the T-th tick.
- Transition edge: the state changes and the datapath count goes to 0 on the same edge. Lamps update in the following cycle.
- `btn` at cycle n, when DARK has already saturated: `req_pending`=1 at n+1, the transition fires at the n+1 edge, and `veh_yellow`=1 at n+2.
- `btn` earlier in DARK: served on the cycle after `count` reaches `T_DARK`, i.e. the cycle after the `T_DARK`-th tick.
- `tick` and `btn` together: both are honoured independently.

## Configuration
`HAWK_COUNTDOWN_EN`:
- Defined: `countdown` = `T_CLEAR` − `count` during CLEAR and 0 elsewhere. It is computed in 5 bits and truncated to 4, so it never underflows because `count` ≤ `T_CLEAR`-1.
- Undefined: `countdown` is tied to 0 and the subtractor is not built.

## Test plan
All scenarios use default parameters.

1. Reset, then 6 ticks, then `btn`: `clr_count`=1 for the init cycle, `count` saturates at 5, and `veh_yellow` goes high 2 cycles after `btn`.
2. Full cycle: ticks spent per phase are FLASH_Y 4, SOLID_Y 3, WALK 7, CLEAR 10, then DARK. `veh_yellow` toggles 1,0,1,0 in FLASH_Y and the reds alternate in CLEAR.
3. `btn` at tick 1 of DARK: FLASH_Y entered only after the 5th tick.
4. `btn` during WALK: the crossing completes, DARK lasts exactly 5 ticks, then FLASH_Y re-enters with no further `btn`. A `btn` on the DARK→FLASH_Y cycle leaves `req_pending`=0.
5. `rst_n` low mid-WALK: outputs show DARK values immediately, no request is pending afterwards, and `count` is cleared before the first tick is counted.
6. With `HAWK_COUNTDOWN_EN`: `countdown` reads 10,9,…,1 through CLEAR and 0 in WALK. Without the macro, it is 0 throughout.

Source files
------------

// File: rtl/hawk_controller.sv
// Sequencing FSM and lamp decoder for the HAWK pedestrian beacon; drives the shared datapath seconds counter.
// Optional pedestrian countdown display is built only when HAWK_COUNTDOWN_EN is defined.
module hawk_controller #(
  parameter int T_DARK    = 5,
  parameter int T_FLASH_Y = 4,
  parameter int T_SOLID_Y = 3,
  parameter int T_WALK    = 7,
  parameter int T_CLEAR   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       btn,
  input  logic [3:0] count,
  output logic       clr_count,
  output logic       inc_count,
  output logic       veh_yellow,
  output logic       veh_red_l,
  output logic       veh_red_r,
  output logic       ped_walk,
  output logic       ped_dontwalk,
  output logic [3:0] countdown,
  output logic [2:0] state
);

  if (T_DARK < 1 || T_DARK > 15) begin : g_bad_t_dark
    $error("hawk_controller: T_DARK must be in 1..15");
  end
  if (T_FLASH_Y < 1 || T_FLASH_Y > 15) begin : g_bad_t_flash_y
    $error("hawk_controller: T_FLASH_Y must be in 1..15");
  end
  if (T_SOLID_Y < 1 || T_SOLID_Y > 15) begin : g_bad_t_solid_y
    $error("hawk_controller: T_SOLID_Y must be in 1..15");
  end
  if (T_WALK < 1 || T_WALK > 15) begin : g_bad_t_walk
    $error("hawk_controller: T_WALK must be in 1..15");
  end
  if (T_CLEAR < 1 || T_CLEAR > 15) begin : g_bad_t_clear
    $error("hawk_controller: T_CLEAR must be in 1..15");
  end

  typedef enum logic [2:0] {
    DARK    = 3'd0,
    FLASH_Y = 3'd1,
    SOLID_Y = 3'd2,
    WALK    = 3'd3,
    CLEAR   = 3'd4
  } phase_e;

  // Count value on the final tick of each timed phase; DARK saturates at its limit.
  localparam logic [3:0] DARK_SAT    = 4'(T_DARK);
  localparam logic [3:0] FLASH_LAST  = 4'(T_FLASH_Y - 1);
  localparam logic [3:0] SOLID_LAST  = 4'(T_SOLID_Y - 1);
  localparam logic [3:0] WALK_LAST   = 4'(T_WALK - 1);
  localparam logic [3:0] CLEAR_LAST  = 4'(T_CLEAR - 1);

  phase_e state_q, state_d;
  logic   init_done;
  logic   req_pending;
  logic   advance;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    advance   = 1'b0;
    inc_count = 1'b0;
    if (init_done) begin
      case (state_q)
        DARK: begin
          inc_count = tick && (count < DARK_SAT);
          if (req_pending && count == DARK_SAT) begin
            advance = 1'b1;
            state_d = FLASH_Y;
          end
        end
        FLASH_Y: begin
          inc_count = tick;
          if (tick && count == FLASH_LAST) begin
            advance = 1'b1;
            state_d = SOLID_Y;
          end
        end
        SOLID_Y: begin
          inc_count = tick;
          if (tick && count == SOLID_LAST) begin
            advance = 1'b1;
            state_d = WALK;
          end
        end
        WALK: begin
          inc_count = tick;
          if (tick && count == WALK_LAST) begin
            advance = 1'b1;
            state_d = CLEAR;
          end
        end
        CLEAR: begin
          inc_count = tick;
          if (tick && count == CLEAR_LAST) begin
            advance = 1'b1;
            state_d = DARK;
          end
        end
        default: begin
          advance = 1'b1;
          state_d = DARK;
        end
      endcase
    end
    clr_count = !init_done || advance;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DARK;
      init_done   <= 1'b0;
      req_pending <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      init_done <= 1'b1;
      state_q   <= state_d;
      // A press coinciding with service is absorbed by that service.
      if (advance && state_d == FLASH_Y) begin
        req_pending <= 1'b0;
      end else if (btn) begin
        req_pending <= 1'b1;
      end
    end
  end

  assign state = state_q;

  always_comb begin
    veh_yellow   = 1'b0;
    veh_red_l    = 1'b0;
    veh_red_r    = 1'b0;
    ped_walk     = 1'b0;
    ped_dontwalk = 1'b0;
    case (state_q)
      DARK: begin
        ped_dontwalk = 1'b1;
      end
      FLASH_Y: begin
        veh_yellow   = ~count[0];
        ped_dontwalk = 1'b1;
      end
      SOLID_Y: begin
        veh_yellow   = 1'b1;
        ped_dontwalk = 1'b1;
      end
      WALK: begin
        veh_red_l = 1'b1;
        veh_red_r = 1'b1;
        ped_walk  = 1'b1;
      end
      CLEAR: begin
        veh_red_l    = ~count[0];
        veh_red_r    = count[0];
        ped_dontwalk = ~count[0];
      end
      default: begin
        ped_dontwalk = 1'b1;
      end
    endcase
  end

`ifdef HAWK_COUNTDOWN_EN
  // count never exceeds T_CLEAR-1 in CLEAR, so the truncated difference is always 1..T_CLEAR.
  logic [4:0] remaining;
  assign remaining = 5'(T_CLEAR) - {1'b0, count};
  assign countdown = (state_q == CLEAR) ? remaining[3:0] : 4'd0;
`else
  assign countdown = 4'd0;
`endif

endmodule
